vdac_track_ctrl: RTL and testbench

Digital tracking controller that sequences the reference DAC of the phase-sync PLL. It samples the DAC comparator output `PHE_SIG`, decides the step direction, and issues one-cycle `EN` pulses with the matching `IN` bit so the DAC reference tracks the sampled voltage. It keeps a mirror of the DAC code, detects lock from direction reversals, and flags saturation at the code bounds.

---
 rtl/vdac_ctrl_pkg.sv | 25 ++
 rtl/vdac_sync2.sv | 21 ++
 rtl/vdac_track_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_vdac_track_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vdac_ctrl_pkg.sv
// Shared types and default constants for the phase-sync PLL reference DAC tracking controller.
package vdac_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } vdac_state_e;

    localparam int unsigned VDAC_CODE_W       = 10;
    localparam int unsigned VDAC_CODE_INIT    = 450;
    localparam int unsigned VDAC_WAIT_CYC     = 4;
    localparam int unsigned VDAC_LOCK_TOGGLES = 8;
    localparam int unsigned VDAC_UNLOCK_RUN   = 4;
    localparam int unsigned VDAC_CNT_W        = 8;

    typedef logic [VDAC_CODE_W-1:0] vdac_code_t;
    typedef logic [VDAC_CNT_W-1:0]  vdac_cnt_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic vdac_cnt_t cnt_sat_inc(input vdac_cnt_t val, input vdac_cnt_t lim);
        return (val >= lim) ? lim : val + vdac_cnt_t'(1);
    endfunction

endpackage

// File: rtl/vdac_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output, reset to 0.
module vdac_sync2 (
    input  logic DACCLK,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge DACCLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/vdac_track_ctrl.sv
// Reference DAC tracking controller: bang-bang stepping, code mirror, lock and saturation flags.
// Define VDAC_LOCK_FREEZE_EN to stop stepping while LOCKED is high.
module vdac_track_ctrl
    import vdac_ctrl_pkg::*;
#(
    parameter int unsigned CODE_W       = VDAC_CODE_W,
    parameter int unsigned CODE_INIT    = VDAC_CODE_INIT,
    parameter int unsigned WAIT_CYC     = VDAC_WAIT_CYC,
    parameter int unsigned LOCK_TOGGLES = VDAC_LOCK_TOGGLES,
    parameter int unsigned UNLOCK_RUN   = VDAC_UNLOCK_RUN
) (
    input  logic              DACCLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              PHE_SIG,
    output logic              EN,
    output logic              IN,
    output logic [CODE_W-1:0] DAC_CODE,
    output logic              LOCKED,
    output logic              SAT,
    output logic              BUSY
);

    localparam int unsigned       WCNT_W     = $clog2(WAIT_CYC);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(WAIT_CYC - 1);
    localparam logic [CODE_W-1:0] CODE_RST   = CODE_W'(CODE_INIT);
    localparam logic [CODE_W-1:0] CODE_MAX   = {CODE_W{1'b1}};
    localparam vdac_cnt_t         LOCK_LIM   = vdac_cnt_t'(LOCK_TOGGLES);
    localparam vdac_cnt_t         UNLOCK_LIM = vdac_cnt_t'(UNLOCK_RUN);

    vdac_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              en_q, en_d;
    logic              in_q, in_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              locked_q, locked_d;
    logic              sat_q, sat_d;
    logic              busy_q, busy_d;
    vdac_cnt_t         rev_cnt_q, rev_cnt_d;
    vdac_cnt_t         run_cnt_q, run_cnt_d;
    logic              prev_dir_q, prev_dir_d;
    logic              prev_vld_q, prev_vld_d;

    logic phe_s;
    logic decide;
    logic dir;
    logic at_bound;
    logic freeze;

    vdac_sync2 u_sync (
        .DACCLK (DACCLK),
        .RESET  (RESET),
        .d_i    (PHE_SIG),
        .q_o    (phe_s)
    );

`ifdef VDAC_LOCK_FREEZE_EN
    assign freeze = locked_q;
`else
    assign freeze = 1'b0;
`endif

    assign dir      = phe_s;
    assign at_bound = (dir && (code_q == CODE_MAX)) || (!dir && (code_q == '0));

    // Sequencer; decide marks the last WAIT cycle, whose closing edge enters STEP.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        decide     = 1'b0;
        if (!START) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT;
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = STEP;
                        decide  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end
                STEP: state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        en_d       = 1'b0;
        in_d       = in_q;
        code_d     = code_q;
        locked_d   = locked_q;
        sat_d      = sat_q;
        rev_cnt_d  = rev_cnt_q;
        run_cnt_d  = run_cnt_q;
        prev_dir_d = prev_dir_q;
        prev_vld_d = prev_vld_q;
        busy_d     = (state_d != IDLE);

        // Mirror moves on the same edge the DAC consumes the EN pulse.
        if (en_q) begin
            code_d = in_q ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
        end

        if (state_d == IDLE) begin
            prev_vld_d = 1'b0;
        end

        if (decide) begin
            in_d = dir;
            if (at_bound) begin
                sat_d = 1'b1;
            end else if (!freeze) begin
                en_d  = 1'b1;
                sat_d = 1'b0;
            end

            prev_dir_d = dir;
            prev_vld_d = 1'b1;

            // The first decision after IDLE has nothing to compare against.
            if (prev_vld_q) begin
                if (dir != prev_dir_q) begin
                    rev_cnt_d = cnt_sat_inc(rev_cnt_q, LOCK_LIM);
                    run_cnt_d = vdac_cnt_t'(1);
                end else begin
                    rev_cnt_d = '0;
                    run_cnt_d = cnt_sat_inc(run_cnt_q, UNLOCK_LIM);
                end
                if (rev_cnt_d == LOCK_LIM) begin
                    locked_d = 1'b1;
                end
                if (locked_q && (run_cnt_d == UNLOCK_LIM)) begin
                    locked_d  = 1'b0;
                    rev_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge DACCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            en_q       <= 1'b0;
            in_q       <= 1'b0;
            code_q     <= CODE_RST;
            locked_q   <= 1'b0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            rev_cnt_q  <= '0;
            run_cnt_q  <= '0;
            prev_dir_q <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            en_q       <= en_d;
            in_q       <= in_d;
            code_q     <= code_d;
            locked_q   <= locked_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            rev_cnt_q  <= rev_cnt_d;
            run_cnt_q  <= run_cnt_d;
            prev_dir_q <= prev_dir_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign EN       = en_q;
    assign IN       = in_q;
    assign DAC_CODE = code_q;
    assign LOCKED   = locked_q;
    assign SAT      = sat_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_vdac_track_ctrl.sv
// Directed bench for vdac_track_ctrl: default instance plus a 4-bit instance for code bounds.
module tb_vdac_track_ctrl;

    logic       DACCLK = 1'b0;
    logic       RESET;
    logic       start;
    logic       phe_val;
    logic       phe_mode;
    int         target;
    logic       phe;
    logic       en, in_b, locked, sat, busy;
    logic [9:0] dac_code;

    logic       start_s, phe_sat;
    logic       en_s, in_s, locked_s, sat_s, busy_s;
    logic [3:0] code_s;

    int n_chk;
    int n_fail;

    always #5 DACCLK = ~DACCLK;

    // Comparator: either a constant level or VSMP modelled as a target code.
    assign phe = phe_mode ? (target > int'(dac_code)) : phe_val;

    vdac_track_ctrl u_dut (
        .DACCLK   (DACCLK),
        .RESET    (RESET),
        .START    (start),
        .PHE_SIG  (phe),
        .EN       (en),
        .IN       (in_b),
        .DAC_CODE (dac_code),
        .LOCKED   (locked),
        .SAT      (sat),
        .BUSY     (busy)
    );

    vdac_track_ctrl #(
        .CODE_W    (4),
        .CODE_INIT (14)
    ) u_sat (
        .DACCLK   (DACCLK),
        .RESET    (RESET),
        .START    (start_s),
        .PHE_SIG  (phe_sat),
        .EN       (en_s),
        .IN       (in_s),
        .DAC_CODE (code_s),
        .LOCKED   (locked_s),
        .SAT      (sat_s),
        .BUSY     (busy_s)
    );

    typedef struct {
        logic start;
        logic phe;
        logic en;
        logic in_b;
        int   code;
        logic busy;
        logic locked;
        logic sat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge DACCLK);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic ph, input logic e, input logic i,
                                input int c, input logic b);
        vec_t v;
        v.start  = st;
        v.phe    = ph;
        v.en     = e;
        v.in_b   = i;
        v.code   = c;
        v.busy   = b;
        v.locked = 1'b0;
        v.sat    = 1'b0;
        return v;
    endfunction

    initial begin
        int cnt;
        n_chk    = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        start    = 1'b0;
        phe_val  = 1'b0;
        phe_mode = 1'b0;
        target   = 0;
        start_s  = 1'b0;
        phe_sat  = 1'b0;

        // Expected state after each edge; START/PHE applied just before that edge.
        vecs[0]  = mk(1, 1, 0, 0, 450, 1);
        vecs[1]  = mk(1, 1, 0, 0, 450, 1);
        vecs[2]  = mk(1, 1, 0, 0, 450, 1);
        vecs[3]  = mk(1, 1, 0, 0, 450, 1);
        vecs[4]  = mk(1, 1, 1, 1, 450, 1);
        vecs[5]  = mk(1, 1, 0, 1, 451, 1);
        vecs[6]  = mk(1, 1, 0, 1, 451, 1);
        vecs[7]  = mk(1, 1, 0, 1, 451, 1);
        vecs[8]  = mk(1, 1, 0, 1, 451, 1);
        vecs[9]  = mk(1, 1, 1, 1, 451, 1);
        vecs[10] = mk(1, 1, 0, 1, 452, 1);
        vecs[11] = mk(0, 1, 0, 1, 452, 0);

        repeat (3) tick();
        chk("rst_en", int'(en), 0);
        chk("rst_in", int'(in_b), 0);
        chk("rst_code", int'(dac_code), 450);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_code_sat_inst", int'(code_s), 14);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            start   = vecs[i].start;
            phe_val = vecs[i].phe;
            tick();
            chk($sformatf("vec%0d_en", i), int'(en), int'(vecs[i].en));
            chk($sformatf("vec%0d_in", i), int'(in_b), int'(vecs[i].in_b));
            chk($sformatf("vec%0d_code", i), int'(dac_code), vecs[i].code);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].locked));
            chk($sformatf("vec%0d_sat", i), int'(sat), int'(vecs[i].sat));
        end

        // START dropped while the EN pulse is on the wire.
        start = 1'b1;
        for (int i = 0; i < 20 && !en; i++) tick();
        chk("stop_en_seen", int'(en), 1);
        chk("stop_code_before", int'(dac_code), 452);
        start = 1'b0;
        tick();
        chk("stop_en_low", int'(en), 0);
        chk("stop_busy_low", int'(busy), 0);
        chk("stop_code_after", int'(dac_code), 453);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (en || dac_code != 10'd453) cnt++;
        end
        chk("stop_hold_cycles", cnt, 0);
        start = 1'b1;
        for (int i = 0; i < 20 && !en; i++) tick();
        chk("resume_en_seen", int'(en), 1);
        tick();
        chk("resume_code", int'(dac_code), 454);

        // Track toward 460; lock lands on the 8th reversal, an up step from 459.
        phe_mode = 1'b1;
        target   = 460;
        for (int i = 0; i < 300 && !locked; i++) tick();
        chk("lock_seen", int'(locked), 1);
        chk("lock_code", int'(dac_code), 459);
        chk("lock_en", int'(en), 1);
        chk("lock_in", int'(in_b), 1);
        tick();
        chk("lock_code_next", int'(dac_code), 460);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!locked || dac_code < 10'd459 || dac_code > 10'd460) cnt++;
        end
        chk("lock_hold_cycles", cnt, 0);

        // Retarget to 440 right at an up step from 459: downs at 460,459,458,457 unlock.
        for (int i = 0; i < 20 && !(en && in_b); i++) tick();
        chk("retarget_code", int'(dac_code), 459);
        target = 440;
        for (int i = 0; i < 100 && locked; i++) tick();
        chk("unlock_seen", int'(locked), 0);
        chk("unlock_code", int'(dac_code), 457);
        chk("unlock_en", int'(en), 1);
        chk("unlock_in", int'(in_b), 0);
        for (int i = 0; i < 200 && dac_code != 10'd440; i++) tick();
        chk("reach_440", int'(dac_code), 440);
        chk("reach_440_unlocked", int'(locked), 0);

        // Relock at 460, then reset mid-WAIT.
        target = 460;
        for (int i = 0; i < 300 && dac_code != 10'd460; i++) tick();
        chk("reach_460", int'(dac_code), 460);
        for (int i = 0; i < 200 && !locked; i++) tick();
        chk("relock_seen", int'(locked), 1);
        chk("relock_code", int'(dac_code), 459);
        tick();
        tick();
        chk("prereset_code", int'(dac_code), 460);
        chk("prereset_busy", int'(busy), 1);
        RESET = 1'b1;
        #1;
        chk("async_rst_code", int'(dac_code), 450);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_en", int'(en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_in", int'(in_b), 0);
        start    = 1'b0;
        phe_mode = 1'b0;
        tick();
        RESET = 1'b0;
        tick();

        // Narrow instance: climb 14 -> 15 and then saturate.
        start_s = 1'b1;
        phe_sat = 1'b1;
        for (int i = 0; i < 60 && !sat_s; i++) tick();
        chk("sat_hi_seen", int'(sat_s), 1);
        chk("sat_hi_code", int'(code_s), 15);
        chk("sat_hi_en", int'(en_s), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (en_s) cnt++;
        end
        chk("sat_hi_no_en", cnt, 0);
        chk("sat_hi_hold", int'(sat_s), 1);
        phe_sat = 1'b0;
        for (int i = 0; i < 30 && !en_s; i++) tick();
        chk("sat_clr_en", int'(en_s), 1);
        chk("sat_clr_in", int'(in_s), 0);
        chk("sat_clr_sat", int'(sat_s), 0);
        tick();
        chk("sat_clr_code", int'(code_s), 14);
        for (int i = 0; i < 200 && !sat_s; i++) tick();
        chk("sat_lo_seen", int'(sat_s), 1);
        chk("sat_lo_code", int'(code_s), 0);
        chk("sat_lo_en", int'(en_s), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
